// File: rtl/mac_acc_requant.sv
// rtl/mac_acc_requant.sv - group accumulator, int8 requantizer and output FIFO for the dot-product MAC
module mac_acc_requant #(
    parameter int ACC_W = 32,
    parameter int DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_nrst,
    input  logic        i_valid,
    input  logic [18:0] i_res,
    input  logic        i_last,
    input  logic [15:0] i_bias,
    input  logic [3:0]  i_shift,
    input  logic        i_clr_ovf,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [7:0]  o_data,
    output logic        o_sat,
    output logic        o_ovf,
    output logic        o_busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W:0]   Q_MAX   = (ACC_W+1)'(127);
    localparam logic signed [ACC_W:0]   Q_MIN   = (ACC_W+1)'(-128);
    localparam logic [AW:0]             FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    // Saturating signed add: one guard bit detects overflow, which clamps instead of wrapping.
    function automatic logic signed [ACC_W-1:0] sat_add(
        input logic signed [ACC_W-1:0] a,
        input logic signed [ACC_W-1:0] b
    );
        logic signed [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        if (s[ACC_W] != s[ACC_W-1]) begin
            return s[ACC_W] ? ACC_MIN : ACC_MAX;
        end
        return s[ACC_W-1:0];
    endfunction

    state_t                   state, state_nxt;
    logic signed [ACC_W-1:0]  acc, acc_nxt;
    logic [3:0]               grp_shift, grp_shift_nxt;

    logic signed [ACC_W-1:0]  res_x, bias_x, first_sum, acc_sum;

    logic                     s2_load;
    logic signed [ACC_W-1:0]  s2_val_nxt;
    logic [3:0]               s2_shift_nxt;
    logic                     s2_valid;
    logic signed [ACC_W-1:0]  s2_val;
    logic [3:0]               s2_shift;

    logic signed [ACC_W:0]    v_ext, v_rnd, v_shr;
    logic [7:0]               q_data;
    logic                     q_sat;

    logic [8:0]               mem [DEPTH];
    logic [AW-1:0]            wr_ptr, rd_ptr;
    logic [AW:0]              count;
    logic                     fifo_full, fifo_empty, push, pop, wr_en, drop;

    assign res_x     = {{(ACC_W-19){i_res[18]}}, i_res};
    assign bias_x    = {{(ACC_W-16){i_bias[15]}}, i_bias};
    assign first_sum = sat_add(res_x, bias_x);
    assign acc_sum   = sat_add(acc, res_x);

    // Group FSM: bias and shift are taken on the first beat; the last beat hands the total to stage 2.
    always_comb begin
        state_nxt     = state;
        acc_nxt       = acc;
        grp_shift_nxt = grp_shift;
        s2_load       = 1'b0;
        s2_val_nxt    = s2_val;
        s2_shift_nxt  = s2_shift;
        case (state)
            IDLE: begin
                if (i_valid) begin
                    if (i_last) begin
                        s2_load      = 1'b1;
                        s2_val_nxt   = first_sum;
                        s2_shift_nxt = i_shift;
                    end else begin
                        acc_nxt       = first_sum;
                        grp_shift_nxt = i_shift;
                        state_nxt     = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (i_valid) begin
                    if (i_last) begin
                        s2_load      = 1'b1;
                        s2_val_nxt   = acc_sum;
                        s2_shift_nxt = grp_shift;
                        acc_nxt      = '0;
                        state_nxt    = IDLE;
                    end else begin
                        acc_nxt = acc_sum;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                acc_nxt   = '0;
            end
        endcase
    end

    // Stage 1 state: FSM state, running accumulator and the group's captured shift.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state     <= IDLE;
            acc       <= '0;
            grp_shift <= '0;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            grp_shift <= grp_shift_nxt;
        end
    end

    // Stage 2: completed group value travels with the shift it was captured with.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            s2_valid <= 1'b0;
            s2_val   <= '0;
            s2_shift <= '0;
        end else begin
            s2_valid <= s2_load;
            if (s2_load) begin
                s2_val   <= s2_val_nxt;
                s2_shift <= s2_shift_nxt;
            end
        end
    end

    // Stage 3: round half toward +inf, arithmetic shift, clamp to int8; one guard bit keeps the rounding add from wrapping.
    always_comb begin
        v_ext = {s2_val[ACC_W-1], s2_val};
        v_rnd = v_ext;
        if (s2_shift != 4'd0) begin
            v_rnd = v_ext + ((ACC_W+1)'(1) << (s2_shift - 4'd1));
        end
        v_shr  = v_rnd >>> s2_shift;
        q_data = v_shr[7:0];
        q_sat  = 1'b0;
        if (v_shr > Q_MAX) begin
            q_data = 8'h7f;
            q_sat  = 1'b1;
        end else if (v_shr < Q_MIN) begin
            q_data = 8'h80;
            q_sat  = 1'b1;
        end
    end

    assign fifo_full  = (count == FULL_CNT);
    assign fifo_empty = (count == '0);
    assign push       = s2_valid;
    assign pop        = !fifo_empty && i_ready;
    assign wr_en      = push && (!fifo_full || pop);
    assign drop       = push && fifo_full && !pop;

    // FIFO storage; the head is only exposed while the FIFO is non-empty, so it needs no reset.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {q_sat, q_data};
        end
    end

    // FIFO pointers and occupancy; a push into a full FIFO is only dropped when no pop frees a slot.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow: a drop wins over a simultaneous clear.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            o_ovf <= 1'b0;
        end else if (drop) begin
            o_ovf <= 1'b1;
        end else if (i_clr_ovf) begin
            o_ovf <= 1'b0;
        end
    end

    assign o_valid = !fifo_empty;
    assign o_data  = fifo_empty ? 8'h00 : mem[rd_ptr][7:0];
    assign o_sat   = fifo_empty ? 1'b0  : mem[rd_ptr][8];
    assign o_busy  = (state == ACCUM) || s2_valid;

endmodule

// File: doc/mac_acc_requant.md
# mac_acc_requant

Downstream stage of the 8-lane int8 dot-product MAC. It accumulates successive 19-bit signed dot products into one group result and adds a bias. It then requantizes the result to int8 with a rounding arithmetic right shift and saturation. Results are buffered in a small output FIFO with a valid/ready handshake. The MAC has no stall input, so this block absorbs backpressure and reports lost results through a sticky overflow flag.

## Interface
Parameters:
- ACC_W, 32, accumulator width in bits (at least 24).
- DEPTH, 4, output FIFO depth in entries (power of two, at least 2).

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_nrst  input  1  reset; asynchronous, active-low.
- i_valid  input  1  i_res carries a valid dot product this cycle.
- i_res  input  19  signed dot product from the MAC.
- i_last  input  1  qualified by i_valid; marks the final beat of a group.
- i_bias  input  16  signed bias; sign-extended to ACC_W.
- i_shift  input  4  right-shift amount, 0..15.
- i_clr_ovf  input  1  clears o_ovf.
- o_valid  output  1  o_data and o_sat are valid.
- i_ready  input  1  consumer accepts the FIFO head this cycle.
- o_data  output  8  signed requantized result.
- o_sat  output  1  set when o_data was clamped.
- o_ovf  output  1  sticky flag; a result was dropped because the FIFO was full.
- o_busy  output  1  a group is open, or stage 2 holds data.

## Operation
Group FSM states:
- IDLE: no group is open.
  - A beat with i_valid=1 and i_last=0: acc <= sx(i_res) + sx(i_bias). Go to ACCUM.
  - A beat with i_valid=1 and i_last=1: single-beat group. Stage-2 value = sx(i_res) + sx(i_bias). Stay in IDLE.
- ACCUM: a group is open.
  - Each beat with i_valid=1 and i_last=0: acc <= sat(acc + sx(i_res)).
  - A beat with i_valid=1 and i_last=1: stage-2 value = sat(acc + sx(i_res)). Clear acc. Go to IDLE.
  - i_valid=0: hold acc and state.

Configuration sampling:
- i_bias is added on the first beat of a group.
- i_shift is captured on the first beat of a group and used for the whole group.
- Changing i_bias or i_shift mid-group has no effect on that group.

Arithmetic:
- All additions saturate to the signed ACC_W range and never wrap.
- Requantization of value v with captured shift s:
  - s=0: r = v.
  - s>0: r = (v + 2^(s-1)) >>> s. This rounds half toward +inf.
- Output clamp: o_data = clamp(r, -128, 127). o_sat = 1 when clamping was applied.

Pipeline:
- Stage 1 is the accumulator.
- Stage 2 registers the group value together with its captured shift.
- Stage 3 performs the shift, round and saturate, then writes the FIFO. It writes one entry per group.

FIFO:
- First-word-fall-through: o_data and o_sat come from the head entry.
- o_valid = FIFO not empty.
- Pop on o_valid && i_ready.
- Push while full without a pop in the same cycle: the result is dropped and o_ovf is set.
- Push while full with a pop in the same cycle: both succeed and no overflow is flagged.
- o_ovf clear: i_clr_ovf clears o_ovf, but a drop in the same cycle has priority and o_ovf stays 1.
- Data ordering: results leave in group order, and dropped results leave no gap marker.

Unexpected inputs:
- i_last while i_valid=0: ignored.

## Timing
- Reset values: state=IDLE, acc=0, FIFO empty, o_valid=0, o_data=0, o_sat=0, o_ovf=0, o_busy=0.
- Reset mid-operation discards the open group, stage 2 and all FIFO contents.
- Latency: the i_last beat is sampled at edge t, the FIFO write occurs at edge t+1, and o_valid=1 follows the t+1 edge when the FIFO was empty.
- Throughput: one beat per cycle, sustained indefinitely. A single-beat group is accepted every cycle.
- Back-to-back groups: an i_last beat followed by a first beat in the next cycle needs no bubble.
- i_ready may be held high permanently. Each entry is then presented for exactly one cycle.
- o_data and o_sat stay stable while o_valid=1 and i_ready=0.

## Test plan
- Reset and idle: after reset with i_valid=0 for 10 cycles, o_valid=0, o_ovf=0 and o_busy=0.
- Rounding, single-beat groups:
  - i_res=-10, bias=0, shift=2 gives o_data=-2, o_sat=0.
  - i_res=1000, bias=24, shift=3 gives o_data=127, o_sat=1.
- Multi-beat group:
  - Beats 100, 200, -50 (last), bias=0, shift=2 give o_data=63.
  - A shift change to 7 after the first beat has no effect: the result is still 63.
- Back-to-back stream under full backpressure:
  - DEPTH=4, i_ready=0, six single-beat groups 1..6 with shift=0.
  - Four entries (1..4) are held, then o_ovf=1.
  - Setting i_ready=1 drains 1, 2, 3, 4 in order.
- Full FIFO with simultaneous push and pop: no drop occurs and o_ovf stays 0.
  - i_clr_ovf in the same cycle as a drop leaves o_ovf=1.
- Accumulator saturation and reset:
  - 200 beats of -262144 then last, bias=0, shift=15: no wrap, and o_data=-128 with o_sat=1.
  - Asserting i_nrst=0 mid-group empties the FIFO immediately and the FSM returns to IDLE.
